// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, oversampling constants and parity helper.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  function automatic logic calc_parity(input logic [8:0] data, input logic par_typ);
    return par_typ ? ~^data : ^data;
  endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= {2{RST_VAL}};
    else sync_q <= {sync_q[0], d};
  assign q = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (start, data LSB first, parity, stop).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PAR_TYP = 0,
  parameter int SB_TICK = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);
  localparam int TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  logic rxs;
  uart_rx_state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic perr_q, perr_d, arm_q, arm_d;
  logic parity_err_q, parity_err_d, frame_err_q, frame_err_d, rx_done_q, rx_done_d;
  uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rxs));
  // arm_q blocks re-triggering on a held-low line until it has been seen high again
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    bit_d = bit_q;
    shift_d = shift_q;
    perr_d = perr_q;
    arm_d = rxs ? 1'b1 : arm_q;
    rx_data_d = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d = frame_err_q;
    rx_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d = '0;
        if (!rxs && arm_q) state_d = START;
      end
      START: if (tick) begin
        tick_d = tick_q + 1'b1;
        if (tick_q == TW'(MID_SAMPLE)) begin
          tick_d = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: if (tick) begin
        tick_d = tick_q + 1'b1;
        if (tick_q == TW'(OVERSAMPLE - 1)) begin
          tick_d = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 4'(DATA_BITS - 1)) state_d = PARITY;
        end
      end
      PARITY: if (tick) begin
        tick_d = tick_q + 1'b1;
        if (tick_q == TW'(OVERSAMPLE - 1)) begin
          tick_d = '0;
          perr_d = rxs != calc_parity(9'(shift_q), PAR_TYP[0]);
          state_d = STOP;
        end
      end
      STOP: if (tick) begin
        tick_d = tick_q + 1'b1;
        if (tick_q == TW'(SB_TICK - 1)) begin
          tick_d = '0;
          rx_data_d = shift_q;
          parity_err_d = perr_q;
          frame_err_d = ~rxs;
          rx_done_d = 1'b1;
          arm_d = rxs;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d = '0;
        bit_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      perr_q <= 1'b0;
      arm_q <= 1'b1;
      rx_data_q <= '0;
      parity_err_q <= 1'b0;
      frame_err_q <= 1'b0;
      rx_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      perr_q <= perr_d;
      arm_q <= arm_d;
      rx_data_q <= rx_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q <= frame_err_d;
      rx_done_q <= rx_done_d;
    end
  assign rx_data = rx_data_q;
  assign rx_done = rx_done_q;
  assign parity_err = parity_err_q;
  assign frame_err = frame_err_q;
  assign rx_busy = state_q != IDLE;
endmodule
